// File: rtl/priority_encoder_4to2_pkg.sv
// Shared FSM state encodings, overrun counter width and the priority encode helper
// for priority_encoder_4to2.
package priority_encoder_4to2_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StPresent = 2'd1,
      StAcked   = 2'd2
   } state_e;

   localparam int unsigned OvrCntWidth = 8;

   // Highest set line wins; all-zero lines encode to 0.
   function automatic logic [1:0] encode_prio(input logic [3:0] lines);
      if (lines[3]) return 2'd3;
      if (lines[2]) return 2'd2;
      if (lines[1]) return 2'd1;
      return 2'd0;
   endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one request line.
module debounce_sync #(
   parameter int unsigned DebounceCycles = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic db_o
);

   logic       sync1_q, sync2_q;
   logic       db_q, db_d;
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         db_q    <= 1'b0;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
      end
   end

   // Counts samples that disagree with the accepted level; an agreeing sample restarts.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
         if (cnt_q == 8'(DebounceCycles - 1)) begin
            db_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   assign db_o = db_q;

endmodule

// File: rtl/priority_encoder_4to2.sv
// Debounced 4-line priority encoder with a valid/ready event handshake and a
// one-entry pending slot; OVERRUN_CNT_EN adds a saturating overrun counter output.
module priority_encoder_4to2
   import priority_encoder_4to2_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [3:0]             D,
   input  logic                   Ready,
   output logic [1:0]             I,
   output logic                   Valid,
   output logic                   Any
`ifdef OVERRUN_CNT_EN
   ,
   output logic [OvrCntWidth-1:0] Ovr_count
`endif
);

   logic [3:0] db;
   logic [1:0] code, ref_code;
   logic       db_any;
   state_e     state_q, state_d;
   logic [1:0] i_q, i_d, last_q, last_d, pend_code_q, pend_code_d;
   logic       pend_q, pend_d, any_q;

   for (genvar g = 0; g < 4; g++) begin : g_line
      debounce_sync #(
         .DebounceCycles(DEBOUNCE_CYCLES)
      ) u_debounce_sync (
         .clk_i(Clk),
         .rst_i(Rst),
         .d_i  (D[g]),
         .db_o (db[g])
      );
   end

   assign code     = encode_prio(db);
   assign db_any   = |db;
   assign ref_code = pend_q ? pend_code_q : i_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= StIdle;
         i_q         <= 2'd0;
         last_q      <= 2'd0;
         pend_q      <= 1'b0;
         pend_code_q <= 2'd0;
         any_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         last_q      <= last_d;
         pend_q      <= pend_d;
         pend_code_q <= pend_code_d;
         any_q       <= db_any;
      end
   end

   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      last_d      = last_q;
      pend_d      = pend_q;
      pend_code_d = pend_code_q;
      unique case (state_q)
         StIdle: begin
            if (db_any) begin
               i_d     = code;
               state_d = StPresent;
            end
         end
         StPresent: begin
            if (Ready) begin
               last_d = i_q;
               pend_d = 1'b0;
               // A pending code matching what just went out carries no new information.
               if (pend_q && (pend_code_q != i_q)) begin
                  i_d = pend_code_q;
               end else begin
                  state_d = StAcked;
               end
            end else if (!db_any) begin
               pend_d = 1'b0;
            end else if (code != ref_code) begin
               pend_d      = 1'b1;
               pend_code_d = code;
            end
         end
         StAcked: begin
            if (!db_any) begin
               state_d = StIdle;
            end else if (code != last_q) begin
               i_d     = code;
               state_d = StPresent;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign I     = i_q;
   assign Valid = (state_q == StPresent);
   assign Any   = any_q;

`ifdef OVERRUN_CNT_EN
   logic                   ovr_evt;
   logic [OvrCntWidth-1:0] ovr_cnt_q;

   assign ovr_evt = (state_q == StPresent) && !Ready && db_any && (code != ref_code);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         ovr_cnt_q <= '0;
      end else if (ovr_evt && (ovr_cnt_q != {OvrCntWidth{1'b1}})) begin
         ovr_cnt_q <= ovr_cnt_q + 1'b1;
      end
   end

   assign Ovr_count = ovr_cnt_q;
`endif

endmodule
